rs_bm_solver: RTL and testbench
===============================

# rs_bm_solver

Iterative Berlekamp-Massey key-equation solver for the RS(255,247) decoder over GF(256), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11d). It sits between the syndrome calculator and the Chien search / Forney stage. It takes the 8 syndromes of one codeword and produces the error-locator polynomial Λ(x), the error-evaluator polynomial Ω(x) and an uncorrectable flag. It instantiates one gf256inv to invert the stored previous discrepancy.

## Interface
- No parameters; field, code length (255) and 2t = 8 are fixed.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle request; sampled only in IDLE.
- synd  input  64  S0..S7, with S_j = synd[8j+7:8j]; sampled on the start edge.
- busy  output  1  high from the cycle after start until done.
- done  output  1  single-cycle pulse; results are valid from this cycle.
- lambda  output  40  Λ0..Λ4, with Λ_i = lambda[8i+7:8i].
- omega  output  32  Ω0..Ω3, with Ω_i = omega[8i+7:8i].
- deg_l  output  4  final LFSR length L (0..8).
- fail  output  1  uncorrectable: L>4 or Λ_L==0.

## Operation
- Registered state:
  - S[0..7].
  - C[0..8] and B[0..8], 8-bit coefficients each.
  - L (4 bits), m (4 bits), b (8 bits), d (8 bits), n (3 bits).
- Field arithmetic: addition is XOR; multiplication is GF(256) mod 0x11d. The inverse of b comes from gf256inv, combinationally from the b register.
- FSM states: IDLE, DISC, UPD, OMEGA, DONE.
- IDLE + start:
  - Load S from synd.
  - Initialise C=1, B=1, L=0, m=1, b=0x01, n=0.
  - Go to DISC.
- DISC: d ← S_n ⊕ Σ_{i=1..min(L,n)} C_i·S_{n-i}. Go to UPD.
- UPD: let C' = C ⊕ (d·b⁻¹)·x^m·B, with terms above x^8 dropped.
  - d==0: m←m+1.
  - d≠0 and 2L≤n: B←C (old value), C←C', L←n+1−L, b←d, m←1.
  - d≠0 and 2L>n: C←C', m←m+1.
  - Then, if n==7, go to OMEGA; otherwise n←n+1 and go to DISC.
- OMEGA:
  - Ω_k ← Σ_{i=0..k} C_i·S_{k−i} for k=0..3.
  - lambda ← C[0..4], deg_l ← L.
  - fail ← (L>4) | (C_L==0 when L≤4).
  - Go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- b is never 0 (it is initialised to 1 and only loaded with a nonzero d), so the 0→0 inverse case never occurs.
- Outputs hold their values until the next OMEGA update.

## Timing
- Reset values:
  - All outputs are 0 (busy=0, done=0, lambda=0, omega=0, deg_l=0, fail=0).
  - State is IDLE; all internal registers are 0.
- Start is sampled at edge E0. busy=1 from E0 until DONE exits.
- DISC/UPD take 2 cycles per iteration: 8 iterations occupy edges E1..E16.
- OMEGA registers at E17. The done pulse and valid outputs are seen in the cycle after E17, i.e. done is first high 17 cycles after the start edge.
- Next start is accepted at the edge where done is high (FSM in DONE→IDLE is not accepting). It is accepted at the earliest one cycle after done.
- start while busy is ignored: no restart and no effect on the running solve.
- rst_n low mid-solve: at the next edge, return to IDLE with all outputs 0. No done is produced for the aborted solve.
- Back-to-back starts give a throughput of one solve per 19 cycles.

## Test plan
- **All zero:** synd=0, start → done at +17: lambda=0x0000000001, omega=0, deg_l=0, fail=0.
- **Single error:** S = 01,02,04,08,10,20,40,80 (Y=1, X=α) → lambda Λ0=01, Λ1=02, rest 00; omega Ω0=01, rest 00; deg_l=1; fail=0.
- **Inconsistent:** S0=01, S1..S7=00 → C=1, L=1, lambda=…01, deg_l=1, fail=1.
- **Protocol:** pulse start at +0, then again at +5 with different synd → only one done, at +17, with results for the first synd. A start one cycle after done is accepted.
- **Reset mid-solve:** start, rst_n=0 at +8 for one cycle → outputs 0, no done pulse. A subsequent start with the single-error vector gives the correct result at +17.
- **Random:** inject ≤4 random errors into random codewords, with reference-model syndromes → lambda/omega/deg_l match a golden BM model, fail=0. With 5+ errors, fail matches the model.

Source files
------------

// File: rtl/rs_bm_solver.sv
// Iterative Berlekamp-Massey key-equation solver for RS(255,247) over GF(256), poly 0x11d.
// Eight DISC/UPD iterations build the locator, then one OMEGA step forms the evaluator.

package rs_bm_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DISC, ST_UPD, ST_OMEGA, ST_DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] sh;
    p  = 8'h00;
    sh = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction
endpackage

module gf256inv
  import rs_bm_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] inv_o
);
  // a^-1 = a^254 = a^2 * a^4 * ... * a^128; an input of zero yields zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  assign inv_o = gf_inv(a_i);
endmodule

module rs_bm_solver
  import rs_bm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] synd,
  output logic        busy,
  output logic        done,
  output logic [39:0] lambda,
  output logic [31:0] omega,
  output logic [3:0]  deg_l,
  output logic        fail
);
  state_t     state_q;
  logic [7:0] s_q  [8];
  logic [7:0] c_q  [9];
  logic [7:0] bp_q [9];
  logic [3:0] l_q;
  logic [3:0] m_q;
  logic [7:0] b_q;
  logic [7:0] d_q;
  logic [2:0] n_q;

  logic [7:0]  b_inv;
  logic [7:0]  coef;
  logic [7:0]  disc_d;
  logic [7:0]  c_upd [9];
  logic [39:0] lambda_d;
  logic [31:0] omega_d;
  logic        fail_d;
  logic        grow_l;

  gf256inv u_inv (
    .a_i   (b_q),
    .inv_o (b_inv)
  );

  assign coef   = gf_mul(d_q, b_inv);
  assign grow_l = ({l_q, 1'b0} <= {2'b00, n_q});

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    disc_d = s_q[n_q];
    for (int i = 1; i < 8; i++) begin
      if (i <= int'(l_q) && i <= int'(n_q)) disc_d = disc_d ^ gf_mul(c_q[i], s_q[n_q - 3'(i)]);
    end
  end

  // C' = C + (d/b) x^m B; coefficients shifted past x^8 fall off the end.
  always_comb begin
    logic [3:0] k;
    for (int j = 0; j < 9; j++) begin
      c_upd[j] = c_q[j];
      k        = 4'(j) - m_q;
      if (j >= int'(m_q)) c_upd[j] = c_q[j] ^ gf_mul(coef, bp_q[k]);
    end
  end

  always_comb begin
    lambda_d = '0;
    omega_d  = '0;
    for (int i = 0; i < 5; i++) lambda_d[8*i +: 8] = c_q[i];
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i <= k; i++) omega_d[8*k +: 8] = omega_d[8*k +: 8] ^ gf_mul(c_q[i], s_q[k-i]);
    end
    fail_d = 1'b1;
    if (l_q <= 4'd4) fail_d = (c_q[l_q[2:0]] == 8'h00);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the syndrome and coefficient arrays are reset too, since the whole datapath must read zero after reset.
      state_q <= ST_IDLE;
      for (int j = 0; j < 8; j++) s_q[j] <= 8'h00;
      for (int j = 0; j < 9; j++) begin
        c_q[j]  <= 8'h00;
        bp_q[j] <= 8'h00;
      end
      l_q    <= '0;
      m_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      n_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lambda <= '0;
      omega  <= '0;
      deg_l  <= '0;
      fail   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int j = 0; j < 8; j++) s_q[j] <= synd[8*j +: 8];
            for (int j = 1; j < 9; j++) begin
              c_q[j]  <= 8'h00;
              bp_q[j] <= 8'h00;
            end
            c_q[0]  <= 8'h01;
            bp_q[0] <= 8'h01;
            l_q     <= 4'd0;
            m_q     <= 4'd1;
            b_q     <= 8'h01;
            n_q     <= 3'd0;
            busy    <= 1'b1;
            state_q <= ST_DISC;
          end
        end
        ST_DISC: begin
          d_q     <= disc_d;
          state_q <= ST_UPD;
        end
        ST_UPD: begin
          if (d_q == 8'h00) begin
            m_q <= m_q + 4'd1;
          end else if (grow_l) begin
            bp_q <= c_q;
            c_q  <= c_upd;
            l_q  <= {1'b0, n_q} + 4'd1 - l_q;
            b_q  <= d_q;
            m_q  <= 4'd1;
          end else begin
            c_q <= c_upd;
            m_q <= m_q + 4'd1;
          end
          if (n_q == 3'd7) begin
            state_q <= ST_OMEGA;
          end else begin
            n_q     <= n_q + 3'd1;
            state_q <= ST_DISC;
          end
        end
        ST_OMEGA: begin
          lambda  <= lambda_d;
          omega   <= omega_d;
          deg_l   <= l_q;
          fail    <= fail_d;
          done    <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_bm_solver.sv
// Self-checking bench for rs_bm_solver: directed vectors, protocol corner cases and random
// codewords with injected errors, checked against log-table field arithmetic models.

module tb_rs_bm_solver;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] synd  = '0;
  logic        busy;
  logic        done;
  logic [39:0] lambda;
  logic [31:0] omega;
  logic [3:0]  deg_l;
  logic        fail;

  int checks = 0;
  int errors = 0;

  int gexp [0:509];
  int glog [0:255];
  int gpoly[0:8];
  int rx   [0:254];

  logic [39:0] r_lambda;
  logic [31:0] r_omega;
  logic [3:0]  r_deg;
  logic        r_fail;
  logic [39:0] e_lambda;
  logic [31:0] e_omega;

  rs_bm_solver dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .synd   (synd),
    .busy   (busy),
    .done   (done),
    .lambda (lambda),
    .omega  (omega),
    .deg_l  (deg_l),
    .fail   (fail)
  );

  always #5 clk = ~clk;

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  function automatic int ginv(input int a);
    return gexp[(255 - glog[a]) % 255];
  endfunction

  task automatic init_field();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i]       = x;
      gexp[i + 255] = x;
      glog[x]       = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 285;
    end
    glog[0] = 0;
    // Generator g(x) = prod_{j=0..7} (x + alpha^j).
    for (int k = 0; k < 9; k++) gpoly[k] = 0;
    gpoly[0] = 1;
    for (int j = 0; j < 8; j++) begin
      for (int k = 8; k > 0; k--) gpoly[k] = gpoly[k-1] ^ gmul(gexp[j], gpoly[k]);
      gpoly[0] = gmul(gexp[j], gpoly[0]);
    end
  endtask

  // Random codeword m(x)g(x) plus nerr random errors; sets syndromes and the expected
  // Lambda = prod(1 + X_k x) and Omega = S(x)Lambda(x) mod x^4.
  task automatic make_word(input int nerr, output logic [63:0] sv);
    int used[255];
    int lam[5];
    int s[8];
    int pos, val, mi, acc;
    for (int i = 0; i < 255; i++) begin
      rx[i]   = 0;
      used[i] = 0;
    end
    for (int i = 0; i < 247; i++) begin
      mi = int'($urandom_range(0, 255));
      for (int k = 0; k < 9; k++) rx[i+k] = rx[i+k] ^ gmul(mi, gpoly[k]);
    end
    lam[0] = 1;
    for (int k = 1; k < 5; k++) lam[k] = 0;
    for (int e = 0; e < nerr; e++) begin
      pos = int'($urandom_range(0, 254));
      while (used[pos] != 0) pos = int'($urandom_range(0, 254));
      used[pos] = 1;
      val = int'($urandom_range(1, 255));
      rx[pos] = rx[pos] ^ val;
      for (int k = 4; k > 0; k--) lam[k] = lam[k] ^ gmul(gexp[pos], lam[k-1]);
    end
    sv = '0;
    for (int j = 0; j < 8; j++) begin
      acc = 0;
      for (int i = 0; i < 255; i++) acc = acc ^ gmul(rx[i], gexp[(i * j) % 255]);
      s[j] = acc;
      sv[8*j +: 8] = 8'(acc);
    end
    e_lambda = '0;
    e_omega  = '0;
    for (int k = 0; k < 5; k++) e_lambda[8*k +: 8] = 8'(lam[k]);
    for (int k = 0; k < 4; k++) begin
      acc = 0;
      for (int i = 0; i <= k; i++) acc = acc ^ gmul(lam[i], s[k-i]);
      e_omega[8*k +: 8] = 8'(acc);
    end
  endtask

  // Textbook Massey recursion on wide arrays; gives the final length and the uncorrectable verdict.
  task automatic bm_model(input logic [63:0] sv, output int len, output logic f);
    int c[16];
    int b[16];
    int t[16];
    int s[8];
    int m, bd, d, coef;
    for (int j = 0; j < 8; j++) s[j] = int'(sv[8*j +: 8]);
    for (int i = 0; i < 16; i++) begin
      c[i] = 0;
      b[i] = 0;
    end
    c[0] = 1;
    b[0] = 1;
    len  = 0;
    m    = 1;
    bd   = 1;
    for (int n = 0; n < 8; n++) begin
      d = s[n];
      for (int i = 1; i <= len; i++) d = d ^ gmul(c[i], s[n-i]);
      if (d == 0) begin
        m++;
      end else begin
        coef = gmul(d, ginv(bd));
        t = c;
        for (int j = m; j < 16; j++) c[j] = c[j] ^ gmul(coef, b[j-m]);
        if (2 * len <= n) begin
          len = n + 1 - len;
          b   = t;
          bd  = d;
          m   = 1;
        end else begin
          m++;
        end
      end
    end
    f = (len > 4) || (c[len] == 0);
  endtask

  // Pulse start, then count cycles after the start edge until done; lat = -1 if it never arrives.
  task automatic run_solve(input logic [63:0] sv, output int lat, output logic busy0);
    @(negedge clk);
    start = 1'b1;
    synd  = sv;
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    lat   = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat      = c;
        r_lambda = lambda;
        r_omega  = omega;
        r_deg    = deg_l;
        r_fail   = fail;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, lambda, omega, deg_l, fail} !== 79'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", {busy, done, lambda, omega, deg_l, fail});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    int lat;
    logic b0;
    run_solve(64'd0, lat, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b, want 1", b0); end
    checks++; if (lat != 17) begin errors++; $display("FAIL zero_latency: got %0d, want 17", lat); end
    checks++; if (r_lambda !== 40'h01) begin errors++; $display("FAIL zero_lambda: got %h, want %h", r_lambda, 40'h01); end
    checks++; if (r_omega !== 32'h0) begin errors++; $display("FAIL zero_omega: got %h, want 0", r_omega); end
    checks++; if (r_deg !== 4'd0) begin errors++; $display("FAIL zero_deg: got %0d, want 0", r_deg); end
    checks++; if (r_fail !== 1'b0) begin errors++; $display("FAIL zero_fail: got %b, want 0", r_fail); end
  endtask

  task automatic test_single_error();
    int lat;
    logic b0;
    run_solve(64'h80402010_08040201, lat, b0);
    checks++; if (lat != 17) begin errors++; $display("FAIL single_latency: got %0d, want 17", lat); end
    checks++; if (r_lambda !== 40'h0201) begin errors++; $display("FAIL single_lambda: got %h, want %h", r_lambda, 40'h0201); end
    checks++; if (r_omega !== 32'h01) begin errors++; $display("FAIL single_omega: got %h, want %h", r_omega, 32'h01); end
    checks++; if (r_deg !== 4'd1) begin errors++; $display("FAIL single_deg: got %0d, want 1", r_deg); end
    checks++; if (r_fail !== 1'b0) begin errors++; $display("FAIL single_fail: got %b, want 0", r_fail); end
  endtask

  task automatic test_inconsistent();
    int lat;
    logic b0;
    run_solve(64'h01, lat, b0);
    checks++; if (lat != 17) begin errors++; $display("FAIL incons_latency: got %0d, want 17", lat); end
    checks++; if (r_lambda !== 40'h01) begin errors++; $display("FAIL incons_lambda: got %h, want %h", r_lambda, 40'h01); end
    checks++; if (r_omega !== 32'h01) begin errors++; $display("FAIL incons_omega: got %h, want %h", r_omega, 32'h01); end
    checks++; if (r_deg !== 4'd1) begin errors++; $display("FAIL incons_deg: got %0d, want 1", r_deg); end
    checks++; if (r_fail !== 1'b1) begin errors++; $display("FAIL incons_fail: got %b, want 1", r_fail); end
  endtask

  // Start A; a second start B at +5 must be ignored; a start held over the done cycle is
  // refused at the DONE edge and taken one edge later, so C finishes 36 cycles after A's start.
  task automatic test_protocol();
    logic [63:0] sva, svb, svc;
    logic [39:0] ea_l, ec_l, ra_l, rc_l;
    logic [31:0] ea_o, ec_o, ra_o, rc_o;
    logic b18, b19;
    int dcyc[$];
    make_word(2, sva); ea_l = e_lambda; ea_o = e_omega;
    make_word(3, svb);
    make_word(1, svc); ec_l = e_lambda; ec_o = e_omega;
    ra_l = '0; ra_o = '0; rc_l = '0; rc_o = '0; b18 = 1'b1; b19 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    synd  = sva;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        dcyc.push_back(c);
        if (c == 17) begin ra_l = lambda; ra_o = omega; end
        if (c == 36) begin rc_l = lambda; rc_o = omega; end
      end
      if (c == 4) begin start = 1'b1; synd = svb; end
      if (c == 5) start = 1'b0;
      if (c == 17) begin start = 1'b1; synd = svc; end
      if (c == 18) b18 = busy;
      if (c == 19) begin start = 1'b0; b19 = busy; end
    end
    checks++; if (dcyc.size() != 2) begin errors++; $display("FAIL proto_done_count: got %0d, want 2", dcyc.size()); end
    checks++; if (dcyc.size() < 1 || dcyc[0] != 17) begin errors++; $display("FAIL proto_first_done: got %0d, want 17", dcyc.size() > 0 ? dcyc[0] : -1); end
    checks++; if (dcyc.size() < 2 || dcyc[1] != 36) begin errors++; $display("FAIL proto_second_done: got %0d, want 36", dcyc.size() > 1 ? dcyc[1] : -1); end
    checks++; if (b18 !== 1'b0) begin errors++; $display("FAIL proto_busy_idle: got %b, want 0", b18); end
    checks++; if (b19 !== 1'b1) begin errors++; $display("FAIL proto_busy_restart: got %b, want 1", b19); end
    checks++; if (ra_l !== ea_l || ra_o !== ea_o) begin errors++; $display("FAIL proto_first_result: got %h/%h, want %h/%h", ra_l, ra_o, ea_l, ea_o); end
    checks++; if (rc_l !== ec_l || rc_o !== ec_o) begin errors++; $display("FAIL proto_second_result: got %h/%h, want %h/%h", rc_l, rc_o, ec_l, ec_o); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] sv;
    logic [78:0] snap;
    int nd, lat;
    logic b0;
    make_word(3, sv);
    nd   = 0;
    snap = '1;
    @(negedge clk);
    start = 1'b1;
    synd  = sv;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (c == 7) rst_n = 1'b0;
      if (c == 8) begin
        snap  = {busy, done, lambda, omega, deg_l, fail};
        rst_n = 1'b1;
      end
    end
    checks++; if (snap !== 79'd0) begin errors++; $display("FAIL midreset_outputs: got %h, want 0", snap); end
    checks++; if (nd != 0) begin errors++; $display("FAIL midreset_no_done: got %0d, want 0", nd); end
    run_solve(64'h80402010_08040201, lat, b0);
    checks++; if (lat != 17) begin errors++; $display("FAIL midreset_latency: got %0d, want 17", lat); end
    checks++; if (r_lambda !== 40'h0201 || r_omega !== 32'h01 || r_deg !== 4'd1 || r_fail !== 1'b0) begin
      errors++;
      $display("FAIL midreset_result: got %h/%h/%0d/%b, want 0201/01/1/0", r_lambda, r_omega, r_deg, r_fail);
    end
  endtask

  task automatic test_random_correctable();
    logic [63:0] sv;
    int nerr, lat;
    logic b0;
    for (int t = 0; t < 30; t++) begin
      nerr = int'($urandom_range(1, 4));
      make_word(nerr, sv);
      run_solve(sv, lat, b0);
      checks++; if (lat != 17) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, want 17", t, lat); end
      checks++; if (r_lambda !== e_lambda) begin errors++; $display("FAIL rand_lambda[%0d]: got %h, want %h", t, r_lambda, e_lambda); end
      checks++; if (r_omega !== e_omega) begin errors++; $display("FAIL rand_omega[%0d]: got %h, want %h", t, r_omega, e_omega); end
      checks++; if (int'(r_deg) != nerr) begin errors++; $display("FAIL rand_deg[%0d]: got %0d, want %0d", t, r_deg, nerr); end
      checks++; if (r_fail !== 1'b0) begin errors++; $display("FAIL rand_fail[%0d]: got %b, want 0", t, r_fail); end
    end
  endtask

  task automatic test_random_heavy();
    logic [63:0] sv;
    int nerr, lat, len;
    logic b0, f;
    for (int t = 0; t < 12; t++) begin
      nerr = int'($urandom_range(5, 8));
      make_word(nerr, sv);
      bm_model(sv, len, f);
      run_solve(sv, lat, b0);
      checks++; if (lat != 17) begin errors++; $display("FAIL heavy_latency[%0d]: got %0d, want 17", t, lat); end
      checks++; if (r_fail !== f) begin errors++; $display("FAIL heavy_fail[%0d]: got %b, want %b", t, r_fail, f); end
      checks++; if (int'(r_deg) != len) begin errors++; $display("FAIL heavy_deg[%0d]: got %0d, want %0d", t, r_deg, len); end
    end
  endtask

  initial begin
    init_field();
    test_reset();
    test_all_zero();
    test_single_error();
    test_inconsistent();
    test_protocol();
    test_reset_mid();
    test_random_correctable();
    test_random_heavy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
